// File: rtl/inst_loader_if.sv
// inst_loader_if: host byte stream and instruction RAM write port between host/bench and loader.
//   byte_valid/byte_data/byte_ready : valid/ready byte stream from the host link
//   mem_we/mem_addr/mem_wdata       : instruction RAM write port driven by the loader
interface inst_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    modport master (output byte_valid, byte_data, input byte_ready, mem_we, mem_addr, mem_wdata);
    modport slave  (input byte_valid, byte_data, output byte_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/inst_loader.sv
// inst_loader: boot-time loader assembling little-endian 32-bit words from a byte stream into instruction RAM.
//   clk, rst (async, active-low)  : clock and reset
//   start, word_count             : load request and word count, sampled only in IDLE
//   bus (slave)                   : byte stream in, RAM write port out
//   cpu_hold                      : holds the CPU while a load is in progress
//   busy, done, error             : status; done/error are one-cycle pulses
module inst_loader #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [15:0] WORD_LIMIT = 16'd256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [15:0]   word_count,
    inst_loader_if.slave  bus,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic          error
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RECV  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]  state;
    logic [1:0]  byte_idx;
    logic [15:0] count;
    logic [15:0] word_idx;
    logic [31:0] word;
    logic [31:0] addr;
    logic        err;

    // Outputs decode state flops only, so there is no path from byte_valid to byte_ready.
    assign bus.byte_ready = state == RECV;
    assign bus.mem_we     = state == WRITE;
    assign bus.mem_addr   = addr;
    assign bus.mem_wdata  = word;
    assign cpu_hold       = state == RECV || state == WRITE;
    assign busy           = state != IDLE;
    assign done           = state == DONE;
    assign error          = err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            byte_idx <= 2'd0;
            count    <= 16'd0;
            word_idx <= 16'd0;
            word     <= 32'd0;
            addr     <= BASE_ADDR;
            err      <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    if (word_count == 16'd0) state <= DONE;
                    else if (word_count > WORD_LIMIT) err <= 1'b1;
                    else begin
                        count    <= word_count;
                        word_idx <= 16'd0;
                        byte_idx <= 2'd0;
                        word     <= 32'd0;
                        addr     <= BASE_ADDR;
                        state    <= RECV;
                    end
                end
                RECV: if (bus.byte_valid) begin
                    word[{byte_idx, 3'b000} +: 8] <= bus.byte_data;
                    byte_idx <= byte_idx + 2'd1;
                    if (byte_idx == 2'd3) state <= WRITE;
                end
                WRITE: if (word_idx == count - 16'd1) state <= DONE;
                else begin
                    // addr tracks BASE_ADDR + 4*word_idx with natural 32-bit wrap
                    word_idx <= word_idx + 16'd1;
                    addr     <= addr + 32'd4;
                    byte_idx <= 2'd0;
                    state    <= RECV;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: directed self-checking bench for inst_loader.
module tb_inst_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] word_count = 16'd0;
    logic        cpu_hold, busy, done, error;
    int          passed = 0;
    int          fails = 0;
    int          total = 0;
    int          done_cnt = 0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];

    inst_loader_if bus();

    inst_loader dut (
        .clk(clk), .rst(rst), .start(start), .word_count(word_count),
        .bus(bus), .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst && bus.mem_we) begin
            wa.push_back(bus.mem_addr);
            wd.push_back(bus.mem_wdata);
        end
        if (rst && done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        while (!bus.byte_ready && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) check("ready_timeout", 32'd0, 32'd1);
        tick();
        if (gap > 0) begin
            bus.byte_valid = 1'b0;
            repeat (gap) tick();
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
    endtask

    task automatic do_start(input logic [15:0] wc);
        start = 1'b1;
        word_count = wc;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        done_cnt = 0;
    endtask

    initial begin
        int bad;
        logic [31:0] w;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        // reset state
        tick();
        tick();
        check("rst_ready", {31'd0, bus.byte_ready}, 32'd0);
        check("rst_we", {31'd0, bus.mem_we}, 32'd0);
        check("rst_addr", bus.mem_addr, 32'h0);
        check("rst_wdata", bus.mem_wdata, 32'h0);
        check("rst_hold", {31'd0, cpu_hold}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        rst = 1'b1;
        tick();

        // two words back-to-back
        clear_log();
        do_start(16'd2);
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_hold", {31'd0, cpu_hold}, 32'd1);
        check("t1_ready", {31'd0, bus.byte_ready}, 32'd1);
        send_word(32'h0000_0013, 0);
        check("t1_we0", {31'd0, bus.mem_we}, 32'd1);
        check("t1_ready_wr", {31'd0, bus.byte_ready}, 32'd0);
        send_word(32'h0010_0093, 0);
        bus.byte_valid = 1'b0;
        check("t1_we1", {31'd0, bus.mem_we}, 32'd1);
        check("t1_addr1", bus.mem_addr, 32'h4);
        check("t1_data1", bus.mem_wdata, 32'h0010_0093);
        check("t1_hold_wr", {31'd0, cpu_hold}, 32'd1);
        tick();
        check("t1_done", {31'd0, done}, 32'd1);
        check("t1_hold_done", {31'd0, cpu_hold}, 32'd0);
        check("t1_we_done", {31'd0, bus.mem_we}, 32'd0);
        tick();
        check("t1_idle_busy", {31'd0, busy}, 32'd0);
        check("t1_done_low", {31'd0, done}, 32'd0);
        check("t1_nwrites", wa.size(), 32'd2);
        check("t1_a0", wa[0], 32'h0);
        check("t1_d0", wd[0], 32'h0000_0013);
        check("t1_a1", wa[1], 32'h4);
        check("t1_d1", wd[1], 32'h0010_0093);
        check("t1_done_cnt", done_cnt, 32'd1);

        // same load with 3-cycle gaps
        clear_log();
        do_start(16'd2);
        send_byte(8'h13, 3);
        check("t2_ready_gap", {31'd0, bus.byte_ready}, 32'd1);
        check("t2_hold_gap", {31'd0, cpu_hold}, 32'd1);
        check("t2_we_gap", {31'd0, bus.mem_we}, 32'd0);
        send_byte(8'h00, 3);
        send_byte(8'h00, 3);
        send_byte(8'h00, 3);
        send_word(32'h0010_0093, 3);
        repeat (3) tick();
        check("t2_nwrites", wa.size(), 32'd2);
        check("t2_a0", wa[0], 32'h0);
        check("t2_d0", wd[0], 32'h0000_0013);
        check("t2_a1", wa[1], 32'h4);
        check("t2_d1", wd[1], 32'h0010_0093);
        check("t2_done_cnt", done_cnt, 32'd1);

        // zero count and over-limit count
        clear_log();
        do_start(16'd0);
        check("t3_done", {31'd0, done}, 32'd1);
        check("t3_hold", {31'd0, cpu_hold}, 32'd0);
        tick();
        check("t3_idle", {31'd0, busy}, 32'd0);
        check("t3_nwrites", wa.size(), 32'd0);
        check("t3_done_cnt", done_cnt, 32'd1);
        do_start(16'd257);
        check("t3_error", {31'd0, error}, 32'd1);
        check("t3_err_busy", {31'd0, busy}, 32'd0);
        tick();
        check("t3_error_low", {31'd0, error}, 32'd0);
        check("t3_err_busy2", {31'd0, busy}, 32'd0);

        // start pulsed mid-load is ignored
        clear_log();
        do_start(16'd2);
        send_byte(8'h11, 0);
        start = 1'b1;
        word_count = 16'd5;
        send_byte(8'h22, 0);
        start = 1'b0;
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        send_word(32'h8877_6655, 0);
        bus.byte_valid = 1'b0;
        repeat (4) tick();
        check("t4_nwrites", wa.size(), 32'd2);
        check("t4_d0", wd[0], 32'h4433_2211);
        check("t4_d1", wd[1], 32'h8877_6655);
        check("t4_done_cnt", done_cnt, 32'd1);
        check("t4_idle", {31'd0, busy}, 32'd0);

        // async reset in the middle of word 1
        clear_log();
        do_start(16'd2);
        send_word(32'h0102_0304, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        bus.byte_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_hold", {31'd0, cpu_hold}, 32'd0);
        check("t5_ready", {31'd0, bus.byte_ready}, 32'd0);
        check("t5_addr", bus.mem_addr, 32'h0);
        check("t5_wdata", bus.mem_wdata, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        clear_log();
        do_start(16'd1);
        send_word(32'hDEAD_BEEF, 0);
        bus.byte_valid = 1'b0;
        repeat (3) tick();
        check("t5_nwrites", wa.size(), 32'd1);
        check("t5_a0", wa[0], 32'h0);
        check("t5_d0", wd[0], 32'hDEAD_BEEF);

        // full 256-word load
        clear_log();
        do_start(16'd256);
        for (int i = 0; i < 256; i++) begin
            w = 32'h5A00_0000 + 32'(i) * 32'h0001_0103;
            send_word(w, 0);
        end
        bus.byte_valid = 1'b0;
        check("t6_hold_last", {31'd0, cpu_hold}, 32'd1);
        tick();
        check("t6_done", {31'd0, done}, 32'd1);
        tick();
        check("t6_nwrites", wa.size(), 32'd256);
        bad = 0;
        for (int i = 0; i < wa.size(); i++) begin
            w = 32'h5A00_0000 + 32'(i) * 32'h0001_0103;
            if (wa[i] !== 32'(i) * 32'd4 || wd[i] !== w) bad++;
        end
        check("t6_seq_errors", bad, 32'd0);
        check("t6_last_addr", wa[wa.size()-1], 32'h3FC);
        check("t6_done_cnt", done_cnt, 32'd1);
        check("t6_idle", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
